uvmt_apb_adv_timer_apb_chkr: RTL and testbench
==============================================

# uvmt_apb_adv_timer_apb_chkr

Parametrised, synthesizable protocol checker and activity monitor for the APB Advanced Timer sub-system bench. It is bound alongside the DUT. It passively observes the APB slave port and the timer event outputs, and tracks APB phase with a state machine. It flags protocol, stability and timeout violations and keeps saturating transfer, slave-error and per-channel event counters that the UVM environment reads through the probe interface.

## Interface
- ADDR_WIDTH, 12, APB address width
- DATA_WIDTH, 32, APB data width
- NUM_CH, 4, number of timer event channels observed (1..16)
- MAX_WAIT, 16, max wait states tolerated in ACCESS before timeout (1..255)
- CNT_WIDTH, 16, width of every counter output

- clk  in  1  bench clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- clr_i  in  1  synchronous clear of sticky errors and counters
- psel_i, penable_i, pwrite_i, pready_i, pslverr_i  in  1 each  observed APB controls
- paddr_i  in  ADDR_WIDTH  observed address
- pwdata_i  in  DATA_WIDTH  observed write data
- ch_event_i  in  NUM_CH  timer event outputs, one bit per channel
- err_proto_o, err_stable_o, err_timeout_o  out  1 each  sticky violation flags
- err_pulse_o  out  1  one-cycle pulse on any newly detected violation
- xfer_cnt_o, slverr_cnt_o  out  CNT_WIDTH  completed transfers / completions with pslverr_i=1
- evt_cnt_o  out  NUM_CH*CNT_WIDTH  per-channel rising-edge counts, channel n at [n*CNT_WIDTH +: CNT_WIDTH]

## Operation
- The FSM state records the phase seen on the previous cycle: IDLE, SETUP, ACCESS.
- IDLE:
  - psel_i=1, penable_i=0 → SETUP; paddr_i, pwrite_i and pwdata_i are captured.
  - psel_i=1, penable_i=1 → proto error, stay IDLE.
  - Otherwise stay IDLE.
- SETUP:
  - psel_i=1, penable_i=1 is required → ACCESS.
  - Any other combination → proto error, IDLE.
- ACCESS (current cycle has psel_i=1, penable_i=1):
  - paddr_i and pwrite_i must equal the captured values. pwdata_i must equal the captured value when pwrite_i=1. Any mismatch → stable error; tracking continues.
  - pready_i=0: the wait counter increments. When the wait counter reaches MAX_WAIT with pready_i still 0 → timeout error, IDLE, wait counter cleared.
  - pready_i=1: completion. xfer_cnt_o increments; slverr_cnt_o also increments if pslverr_i=1. State → IDLE and the wait counter clears. A back-to-back SETUP on the next cycle is therefore legal.
  - psel_i or penable_i dropped before pready_i=1 → proto error, IDLE.
- All counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Multiple violations in one cycle set every relevant sticky flag and produce one err_pulse_o.
- clr_i=1 zeroes sticky flags and all counters. Clear wins over a same-cycle increment, which is dropped. clr_i does not affect FSM state, captured values or the wait counter.

## Timing
- Reset: the FSM goes to IDLE and every output, the wait counter and all captured registers go to 0, asynchronously.
- Flags, err_pulse_o and counters are registered: they update on the edge ending the cycle in which the condition is observed, with 1-cycle latency.
- err_pulse_o is high for exactly one cycle per violating cycle. A flag already set still pulses on a repeat violation.
- Reset asserted mid-transfer abandons the transfer silently: no error and no count. The first cycle after deassertion is evaluated from IDLE.
- A minimum zero-wait transfer takes SETUP+ACCESS (2 cycles); xfer_cnt_o is visible on cycle 3.

## Configuration
- UVMT_APB_ADV_TIMER_CHKR_EVT_CNT_EN:
  - Defined: a per-channel edge detector (previous-value register) and event counters are compiled in. A channel counts once per 0→1 transition of ch_event_i[n].
  - Undefined: no event logic is built, evt_cnt_o is tied to 0 and ch_event_i is ignored.

## Test plan
- Zero-wait write to 0x004 followed back-to-back by a read → xfer_cnt_o=2, no error flags, err_pulse_o never high.
- Write with 3 wait states, then a completion with pslverr_i=1 → xfer_cnt_o=1, slverr_cnt_o=1, no error flags.
- penable_i=1 with no prior SETUP → err_proto_o=1 and a one-cycle err_pulse_o one cycle later; paddr_i changing 0x010→0x014 mid-ACCESS → err_stable_o=1.
- MAX_WAIT=4 with pready_i held 0 → err_timeout_o set after the 4th wait cycle; xfer_cnt_o unchanged; the next clean transfer is counted.
- With the macro defined, NUM_CH=4: ch_event_i[2] pulses 5 times, once held high for 3 cycles → evt_cnt_o channel 2 =5, other channels 0. clr_i coinciding with a 6th edge → channel 2 =0.
- Counter saturation with CNT_WIDTH=4: 20 transfers → xfer_cnt_o=15. Reset_n asserted during ACCESS → all outputs 0, no error flagged.

Source files
------------

// File: rtl/uvmt_apb_adv_timer_apb_chkr.sv
// Passive APB protocol checker and activity monitor for the APB advanced timer bench.
// Optional per-channel event counters: define UVMT_APB_ADV_TIMER_CHKR_EVT_CNT_EN.
module uvmt_apb_adv_timer_apb_chkr #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int MAX_WAIT   = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clr_i,
  input  logic                        psel_i,
  input  logic                        penable_i,
  input  logic                        pwrite_i,
  input  logic                        pready_i,
  input  logic                        pslverr_i,
  input  logic [ADDR_WIDTH-1:0]       paddr_i,
  input  logic [DATA_WIDTH-1:0]       pwdata_i,
  input  logic [NUM_CH-1:0]           ch_event_i,
  output logic                        err_proto_o,
  output logic                        err_stable_o,
  output logic                        err_timeout_o,
  output logic                        err_pulse_o,
  output logic [CNT_WIDTH-1:0]        xfer_cnt_o,
  output logic [CNT_WIDTH-1:0]        slverr_cnt_o,
  output logic [NUM_CH*CNT_WIDTH-1:0] evt_cnt_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [7:0]            wait_cnt, wait_nxt;
  logic                  capture, done, proto_v, stable_v, timeout_v;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // A cycle in SETUP state with psel&penable is the first ACCESS cycle, so
  // SETUP and ACCESS share the access-phase evaluation.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    wait_nxt  = wait_cnt;
    capture   = 1'b0;
    done      = 1'b0;
    proto_v   = 1'b0;
    stable_v  = 1'b0;
    timeout_v = 1'b0;
    unique case (state)
      IDLE: begin
        if (psel_i && !penable_i) begin
          state_nxt = SETUP;
          capture   = 1'b1;
        end else if (psel_i && penable_i) begin
          proto_v = 1'b1;
        end
      end
      SETUP, ACCESS: begin
        if (!(psel_i && penable_i)) begin
          proto_v   = 1'b1;
          state_nxt = IDLE;
          wait_nxt  = '0;
        end else begin
          stable_v = (paddr_i != cap_addr) || (pwrite_i != cap_write) ||
                     (pwrite_i && (pwdata_i != cap_wdata));
          if (pready_i) begin
            done      = 1'b1;
            state_nxt = IDLE;
            wait_nxt  = '0;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_v = 1'b1;
            state_nxt = IDLE;
            wait_nxt  = '0;
          end else begin
            state_nxt = ACCESS;
            wait_nxt  = wait_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM, wait counter and captured transfer attributes; clr_i leaves these alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (capture) begin
        cap_addr  <= paddr_i;
        cap_write <= pwrite_i;
        cap_wdata <= pwdata_i;
      end
    end
  end

  // Sticky flags and counters; a same-cycle clear drops any pending set/increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_proto_o   <= 1'b0;
      err_stable_o  <= 1'b0;
      err_timeout_o <= 1'b0;
      err_pulse_o   <= 1'b0;
      xfer_cnt_o    <= '0;
      slverr_cnt_o  <= '0;
    end else begin
      err_pulse_o <= proto_v | stable_v | timeout_v;
      if (clr_i) begin
        err_proto_o   <= 1'b0;
        err_stable_o  <= 1'b0;
        err_timeout_o <= 1'b0;
        xfer_cnt_o    <= '0;
        slverr_cnt_o  <= '0;
      end else begin
        if (proto_v)   err_proto_o   <= 1'b1;
        if (stable_v)  err_stable_o  <= 1'b1;
        if (timeout_v) err_timeout_o <= 1'b1;
        if (done)      xfer_cnt_o    <= sat_inc(xfer_cnt_o);
        if (done && pslverr_i) slverr_cnt_o <= sat_inc(slverr_cnt_o);
      end
    end
  end

`ifdef UVMT_APB_ADV_TIMER_CHKR_EVT_CNT_EN
  logic [NUM_CH-1:0] evt_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_prev  <= '0;
      evt_cnt_o <= '0;
    end else begin
      evt_prev <= ch_event_i;
      for (int n = 0; n < NUM_CH; n++) begin
        if (clr_i)
          evt_cnt_o[n*CNT_WIDTH +: CNT_WIDTH] <= '0;
        else if (ch_event_i[n] && !evt_prev[n])
          evt_cnt_o[n*CNT_WIDTH +: CNT_WIDTH] <= sat_inc(evt_cnt_o[n*CNT_WIDTH +: CNT_WIDTH]);
      end
    end
  end
`else
  logic unused_ch_event;
  assign unused_ch_event = ^ch_event_i;
  assign evt_cnt_o       = '0;
`endif

endmodule

// File: tb/tb_uvmt_apb_adv_timer_apb_chkr.sv
// Directed self-checking bench for uvmt_apb_adv_timer_apb_chkr (MAX_WAIT=4, CNT_WIDTH=4).
module tb_uvmt_apb_adv_timer_apb_chkr;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NC = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clr_i;
  logic          psel_i, penable_i, pwrite_i, pready_i, pslverr_i;
  logic [AW-1:0] paddr_i;
  logic [DW-1:0] pwdata_i;
  logic [NC-1:0] ch_event_i;
  logic          err_proto_o, err_stable_o, err_timeout_o, err_pulse_o;
  logic [CW-1:0] xfer_cnt_o, slverr_cnt_o;
  logic [NC*CW-1:0] evt_cnt_o;

  int n_vec = 0;
  int n_bad = 0;
  int pulse_seen = 0;

  uvmt_apb_adv_timer_apb_chkr #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC), .MAX_WAIT(4), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clr_i(clr_i),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .ch_event_i(ch_event_i),
    .err_proto_o(err_proto_o), .err_stable_o(err_stable_o),
    .err_timeout_o(err_timeout_o), .err_pulse_o(err_pulse_o),
    .xfer_cnt_o(xfer_cnt_o), .slverr_cnt_o(slverr_cnt_o), .evt_cnt_o(evt_cnt_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err_pulse_o) pulse_seen++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus cycle: apply inputs, cross the rising edge, settle 1ns.
  task automatic drive(input logic sel, input logic en, input logic wr, input logic rdy,
                       input logic err, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    psel_i = sel; penable_i = en; pwrite_i = wr; pready_i = rdy; pslverr_i = err;
    paddr_i = addr; pwdata_i = data;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int waits, input logic err);
    drive(1'b1, 1'b0, wr, 1'b0, 1'b0, addr, data);
    for (int i = 0; i < waits; i++) drive(1'b1, 1'b1, wr, 1'b0, 1'b0, addr, data);
    drive(1'b1, 1'b1, wr, 1'b1, err, addr, data);
  endtask

  task automatic clear();
    clr_i = 1'b1;
    idle();
    clr_i = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic [2:0] exp);
    check(tag, {err_proto_o, err_stable_o, err_timeout_o}, exp);
  endtask

  logic [11:0] evt_pat;
  logic [CW-1:0] evt_exp;

  initial begin
    reset_n = 1'b0; clr_i = 1'b0; ch_event_i = '0;
    psel_i = 0; penable_i = 0; pwrite_i = 0; pready_i = 0; pslverr_i = 0;
    paddr_i = '0; pwdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_flags("reset_flags", 3'b000);
    check("reset_pulse", err_pulse_o, 0);
    check("reset_xfer", xfer_cnt_o, 0);
    check("reset_slverr", slverr_cnt_o, 0);
    check("reset_evt", evt_cnt_o, 0);
    reset_n = 1'b1;
    idle();

    // Zero-wait write then back-to-back read
    apb_xfer(1'b1, 12'h004, 32'hA5A5_0001, 0, 1'b0);
    check("b2b_first_xfer", xfer_cnt_o, 1);
    apb_xfer(1'b0, 12'h004, 32'h0, 0, 1'b0);
    idle();
    check("b2b_xfer", xfer_cnt_o, 2);
    check_flags("b2b_flags", 3'b000);
    check("b2b_no_pulse", pulse_seen, 0);

    // Three wait states, slave error on completion
    clear();
    check("clr_xfer", xfer_cnt_o, 0);
    apb_xfer(1'b1, 12'h008, 32'h0000_1234, 3, 1'b1);
    check("wait_xfer", xfer_cnt_o, 1);
    check("wait_slverr", slverr_cnt_o, 1);
    check_flags("wait_flags", 3'b000);

    // ACCESS without SETUP
    clear();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00C, '0);
    check_flags("noset_flags", 3'b100);
    check("noset_pulse", err_pulse_o, 1);
    idle();
    check("noset_pulse_end", err_pulse_o, 0);
    check("noset_sticky", err_proto_o, 1);

    // Address changes mid-ACCESS
    clear();
    check_flags("clr_flags", 3'b000);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h55);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 32'h55);
    check("stable_before", err_stable_o, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h014, 32'h55);
    check_flags("stable_flags", 3'b010);
    check("stable_xfer", xfer_cnt_o, 1);
    idle();

    // Timeout after MAX_WAIT=4 wait cycles
    clear();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h020, '0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h020, '0);
    check("tmo_not_yet", err_timeout_o, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h020, '0);
    check("tmo_set", err_timeout_o, 1);
    check("tmo_pulse", err_pulse_o, 1);
    check("tmo_xfer", xfer_cnt_o, 0);
    idle();
    check("tmo_no_proto", err_proto_o, 0);
    apb_xfer(1'b0, 12'h020, '0, 1, 1'b0);
    check("tmo_next_xfer", xfer_cnt_o, 1);
    check_flags("tmo_flags", 3'b001);

    // Channel 2 events: 5 rising edges, one held 3 cycles
    clear();
    evt_pat = 12'b0101_0111_0101;
    for (int i = 0; i < 12; i++) begin
      ch_event_i = evt_pat[i] ? 4'b0100 : 4'b0000;
      idle();
    end
`ifdef UVMT_APB_ADV_TIMER_CHKR_EVT_CNT_EN
    evt_exp = 4'd5;
`else
    evt_exp = 4'd0;
`endif
    check("evt_ch2", evt_cnt_o[2*CW +: CW], evt_exp);
    check("evt_others", {evt_cnt_o[3*CW +: CW], evt_cnt_o[0 +: 2*CW]}, 0);
    ch_event_i = 4'b0100;
    clear();
    check("evt_clr_edge", evt_cnt_o[2*CW +: CW], 0);
    idle();
    check("evt_held", evt_cnt_o[2*CW +: CW], 0);
    ch_event_i = '0;

    // Saturation at 15
    clear();
    for (int i = 0; i < 20; i++) apb_xfer(1'b0, 12'h030, '0, 0, 1'b1);
    check("sat_xfer", xfer_cnt_o, 15);
    check("sat_slverr", slverr_cnt_o, 15);

    // Clear coinciding with a completion
    clear();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h040, '0);
    clr_i = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h040, '0);
    clr_i = 1'b0;
    check("clr_wins", xfer_cnt_o, 0);
    apb_xfer(1'b1, 12'h044, 32'h77, 0, 1'b0);
    check("post_clr_xfer", xfer_cnt_o, 1);

    // Reset during ACCESS
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h048, '0);
    check("pre_rst_proto", err_proto_o, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h050, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h050, '0);
    #2 reset_n = 1'b0;
    #1;
    check_flags("rst_flags", 3'b000);
    check("rst_xfer", xfer_cnt_o, 0);
    check("rst_pulse", err_pulse_o, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    apb_xfer(1'b0, 12'h060, '0, 0, 1'b0);
    check("post_rst_xfer", xfer_cnt_o, 1);
    check_flags("post_rst_flags", 3'b000);
    idle();
    check("post_rst_pulse", err_pulse_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
